// File: rtl/tt_gate_input_conditioner.sv
// rtl/tt_gate_input_conditioner.sv - synchronise, debounce and edge-detect raw ui_in pads
//
// Purpose: per-bit input conditioning ahead of the gate logic. Each raw input
// bit passes through a two-flop synchroniser, then a debounce counter that
// accepts a new level only after it has been seen for DEBOUNCE_CYCLES
// consecutive enabled edges. Registered one-cycle rise/fall pulses accompany
// each accepted level change. Bits never interact.
//
// Ports:
//   clk    in   1      system clock, all state on rising edge
//   rst_n  in   1      asynchronous active-low reset
//   ena    in   1      design enable; debounce only advances while high
//   din    in   WIDTH  raw asynchronous inputs
//   dout   out  WIDTH  debounced, synchronised levels
//   rise   out  WIDTH  one-cycle pulse when a dout bit goes 0->1
//   fall   out  WIDTH  one-cycle pulse when a dout bit goes 1->0

module tt_gate_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // The synchroniser ignores ena so that a freshly enabled design sees an
  // already-settled s2 and only has to wait out the debounce window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else if (!ena) begin
        // Disabled: level frozen, any partial qualification is abandoned.
        cnt_q  <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (s2[i] == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          // Mismatch has persisted for the full window: accept it. The
          // pulse is registered alongside the level so both change together.
          level_q <= s2[i];
          cnt_q   <= '0;
          rise_q  <= s2[i];
          fall_q  <= ~s2[i];
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign dout[i] = level_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
  end

endmodule

// File: tb/tb_tt_gate_input_conditioner.sv
// tb/tb_tt_gate_input_conditioner.sv - self-checking bench for tt_gate_input_conditioner

module tb_tt_gate_input_conditioner;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] din;
  logic [7:0] dout4, rise4, fall4;
  logic [7:0] dout1, rise1, fall1;

  tt_gate_input_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din),
    .dout(dout4), .rise(rise4), .fall(fall4)
  );

  tt_gate_input_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din),
    .dout(dout1), .rise(rise1), .fall(fall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a level is accepted once the last dc enabled edges all
  // presented the opposite value; the pads reach the debouncer two edges late.
  logic [7:0] q1, q2;
  logic       rec_ena [4];
  logic [7:0] rec_s2  [4];
  int         hist_len;
  logic [7:0] m_dout [2];
  logic [7:0] m_rise [2];
  logic [7:0] m_fall [2];

  task automatic model_reset();
    q1 = '0;
    q2 = '0;
    hist_len = 0;
    for (int i = 0; i < 4; i++) begin
      rec_ena[i] = 1'b0;
      rec_s2[i]  = '0;
    end
    for (int n = 0; n < 2; n++) begin
      m_dout[n] = '0;
      m_rise[n] = '0;
      m_fall[n] = '0;
    end
  endtask

  task automatic model_edge();
    logic [7:0] seen;
    int dc;
    bit ok;
    seen = q2;
    q2 = q1;
    q1 = din;
    for (int i = 3; i > 0; i--) begin
      rec_ena[i] = rec_ena[i-1];
      rec_s2[i]  = rec_s2[i-1];
    end
    rec_ena[0] = ena;
    rec_s2[0]  = seen;
    if (hist_len < 4) hist_len++;
    for (int n = 0; n < 2; n++) begin
      dc = (n == 0) ? 4 : 1;
      m_rise[n] = '0;
      m_fall[n] = '0;
      for (int b = 0; b < 8; b++) begin
        ok = (hist_len >= dc);
        for (int i = 0; i < dc; i++)
          if (!rec_ena[i] || rec_s2[i][b] == m_dout[n][b]) ok = 0;
        if (ok) begin
          m_dout[n][b] = ~m_dout[n][b];
          if (m_dout[n][b]) m_rise[n][b] = 1'b1;
          else              m_fall[n][b] = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("dout4", dout4, m_dout[0]);
    check("rise4", rise4, m_rise[0]);
    check("fall4", fall4, m_fall[0]);
    check("dout1", dout1, m_dout[1]);
    check("rise1", rise1, m_rise[1]);
    check("fall1", fall1, m_fall[1]);
    check("overlap4", rise4 & fall4, 8'h00);
  endtask

  // Assert reset between edges and confirm outputs clear with no clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_dout4", dout4, 8'h00);
    check("rst_rise4", rise4, 8'h00);
    check("rst_fall4", fall4, 8'h00);
    check("rst_dout1", dout1, 8'h00);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    din   = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Short glitch on bit 0 is discarded by the 4-cycle debouncer.
    din = 8'h01;
    for (int k = 1; k <= 3; k++) step();
    din = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t2_dout", dout4, 8'h00);
      check("t2_rise", rise4, 8'h00);
      check("t2_fall", fall4, 8'h00);
    end

    // Reset, release with all inputs high: acceptance at edge 6.
    din = 8'hFF;
    async_reset();
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k <= 5) check("t1_dout_early", dout4, 8'h00);
      if (k == 6) begin
        check("t1_dout_edge6", dout4, 8'hFF);
        check("t1_rise_edge6", rise4, 8'hFF);
      end
      if (k == 7) check("t1_rise_after", rise4, 8'h00);
      check("t1_fall", fall4, 8'h00);
      if (k == 2) check("dc1_dout_edge2", dout1, 8'h00);
      if (k == 3) check("dc1_dout_edge3", dout1, 8'hFF);
    end

    // Upper nibble falls.
    din = 8'h0F;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 5) check("t3_dout_edge5", dout4, 8'hFF);
      if (k == 6) begin
        check("t3_dout_edge6", dout4, 8'h0F);
        check("t3_fall_edge6", fall4, 8'hF0);
        check("t3_rise_edge6", rise4, 8'h00);
      end
    end

    // Disabled: level frozen; after enable, accepted on the 4th edge.
    din = 8'h00;
    for (int k = 1; k <= 7; k++) step();
    ena = 1'b0;
    din = 8'hAA;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("t4_dout_disabled", dout4, 8'h00);
    end
    ena = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 3) check("t4_dout_edge3", dout4, 8'h00);
      if (k == 4) begin
        check("t4_dout_edge4", dout4, 8'hAA);
        check("t4_rise_edge4", rise4, 8'hAA);
      end
      if (k == 5) check("t4_rise_edge5", rise4, 8'h00);
    end

    // Reset mid-qualification loses all progress.
    din = 8'hFF;
    for (int k = 1; k <= 3; k++) step();
    async_reset();
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) check("t5_dout_edge5", dout4, 8'h00);
      if (k == 6) check("t5_dout_edge6", dout4, 8'hFF);
    end

    // Bit 3 chatters while bit 5 steps cleanly.
    din = 8'h00;
    for (int k = 1; k <= 7; k++) step();
    for (int k = 1; k <= 10; k++) begin
      din = 8'h20 | ((((k - 1) / 2) % 2 == 1) ? 8'h08 : 8'h00);
      step();
      check("t6_bit3", {7'd0, dout4[3]}, 8'h00);
      check("t6_pulse3", {6'd0, rise4[3], fall4[3]}, 8'h00);
      if (k == 5) check("t6_dout_edge5", dout4 & 8'h20, 8'h00);
      if (k == 6) begin
        check("t6_dout_edge6", dout4 & 8'h20, 8'h20);
        check("t6_rise_edge6", rise4, 8'h20);
      end
    end

    // Randomised bit activity with hold lengths around the debounce window.
    for (int seg = 0; seg < 250; seg++) begin
      int hold;
      din  = din ^ 8'($urandom);
      ena  = ($urandom_range(0, 7) != 0);
      hold = $urandom_range(1, 6);
      for (int k = 0; k < hold; k++) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
